// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer for the P7 pipeline.
// Owns HI/LO, models mult/div latency with a busy counter, and raises the
// D-stage stall for HI/LO-dependent instructions.
// Optional feature: define MD_ABORT_EN to let `abort` cancel an in-flight
// operation without committing its result.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        abort,
  input  logic        d_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] p_hi_q, p_hi_d;
  logic [31:0] p_lo_q, p_lo_d;
  logic        go;
  logic        md_op;

`ifndef MD_ABORT_EN
  logic unused_abort;
  assign unused_abort = abort;
`endif

  // Signed 32x32 -> 64 product, returned as {hi, lo}.
  function automatic logic [63:0] mul_signed(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    sx = $signed({{32{x[31]}}, x});
    sy = $signed({{32{y[31]}}, y});
    return 64'(sx * sy);
  endfunction

  // Unsigned 32x32 -> 64 product, returned as {hi, lo}.
  function automatic logic [63:0] mul_unsigned(input logic [31:0] x, input logic [31:0] y);
    return {32'h0, x} * {32'h0, y};
  endfunction

  // Signed divide on magnitudes: quotient truncates toward zero, remainder
  // follows the dividend's sign. 0x80000000 / -1 naturally yields 0x80000000
  // with remainder 0 because the magnitude wraps back to the same pattern.
  // Returns {remainder, quotient}; callers handle y == 0 separately.
  function automatic logic [63:0] div_signed(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] mx, my, q, r;
    mx = x[31] ? (~x + 32'd1) : x;
    my = y[31] ? (~y + 32'd1) : y;
    if (my == 32'd0) return 64'h0;
    q = mx / my;
    r = mx % my;
    if (x[31] ^ y[31]) q = ~q + 32'd1;
    if (x[31])         r = ~r + 32'd1;
    return {r, q};
  endfunction

  // Unsigned divide, returned as {remainder, quotient}.
  function automatic logic [63:0] div_unsigned(input logic [31:0] x, input logic [31:0] y);
    if (y == 32'd0) return 64'h0;
    return {x % y, x / y};
  endfunction

  assign go    = start & ~flush;
  assign md_op = ~op[2];
  assign busy  = (state_q == RUN);
  assign stall = d_md & (busy | (go & md_op));
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Next-state: issue in IDLE, count down and commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          case (op)
            3'd0: begin
              {p_hi_d, p_lo_d} = mul_signed(a, b);
              cnt_d   = 4'(MULT_CYCLES);
              state_d = RUN;
            end
            3'd1: begin
              {p_hi_d, p_lo_d} = mul_unsigned(a, b);
              cnt_d   = 4'(MULT_CYCLES);
              state_d = RUN;
            end
            3'd2: begin
              // Divide by zero leaves HI/LO as they are once committed.
              {p_hi_d, p_lo_d} = (b == 32'd0) ? {hi_q, lo_q} : div_signed(a, b);
              cnt_d   = 4'(DIV_CYCLES);
              state_d = RUN;
            end
            3'd3: begin
              {p_hi_d, p_lo_d} = (b == 32'd0) ? {hi_q, lo_q} : div_unsigned(a, b);
              cnt_d   = 4'(DIV_CYCLES);
              state_d = RUN;
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          hi_d    = p_hi_q;
          lo_d    = p_lo_q;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
`ifdef MD_ABORT_EN
        // Abort wins over a same-edge commit.
        if (abort) begin
          hi_d    = hi_q;
          lo_d    = lo_q;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Testbench for md_sched: scenario tasks with a scoreboard of expected
// {hi, lo} values pushed at issue time and popped when the result lands.
module tb_md_sched;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, flush, abort, d_md;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall;
  logic [31:0] hi, lo;

  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;
  int checks   = 0;
  int failures = 0;

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .abort(abort), .d_md(d_md),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model built on 64-bit arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] h, input logic [31:0] l);
    longint      sx, sy, sq, sr;
    logic [63:0] ux, uy, res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    res = {h, l};
    case (o)
      3'd0: res = 64'(sx * sy);
      3'd1: res = ux * uy;
      3'd2: if (y != 0) begin
              sq = sx / sy;
              sr = sx % sy;
              res = {sr[31:0], sq[31:0]};
            end
      3'd3: if (y != 0) res = {32'(ux % uy), 32'(ux / uy)};
      3'd4: res = {x, l};
      3'd5: res = {h, x};
      default: ;
    endcase
    return res;
  endfunction

  // Present an instruction in E; optionally record its expected outcome.
  task automatic drive_issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit record);
    logic [63:0] e;
    start = 1'b1; op = o; a = x; b = y;
    if (record) begin
      e = model(o, x, y, m_hi, m_lo);
      sb_q.push_back(e);
      {m_hi, m_lo} = e;
    end
  endtask

  // Let the issue edge pass and drop start.
  task automatic clock_issue();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count cycles while busy is high, bounded.
  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
    sb_q.delete();
    checks++; if (hi !== 32'h0)  begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
    checks++; if (lo !== 32'h0)  begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
  endtask

  task automatic test_mult();
    int n;
    logic [63:0] e;
    drive_issue(3'd0, 32'hFFFFFFFE, 32'd3, 1'b1);
    clock_issue();
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL mult_hi_held got=%h exp=%h", hi, 32'h0); end
    wait_busy(n);
    checks++; if (n != MC) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=%0d", n, MC); end
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL mult_result got=%h exp=%h", {hi, lo}, e); end
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) begin failures++; $display("FAIL mult_literal got=%h exp=FFFFFFFFFFFFFFFA", {hi, lo}); end

    drive_issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
    clock_issue();
    wait_busy(n);
    checks++; if (n != MC) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=%0d", n, MC); end
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL multu_result got=%h exp=%h", {hi, lo}, e); end
    checks++; if ({hi, lo} !== 64'h00000002_FFFFFFFA) begin failures++; $display("FAIL multu_literal got=%h exp=00000002FFFFFFFA", {hi, lo}); end
  endtask

  task automatic test_div();
    int n;
    logic [63:0] e;
    drive_issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1);
    clock_issue();
    wait_busy(n);
    checks++; if (n != DC) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=%0d", n, DC); end
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL div_result got=%h exp=%h", {hi, lo}, e); end
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin failures++; $display("FAIL div_literal got=%h exp=FFFFFFFFFFFFFFFD", {hi, lo}); end

    drive_issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    clock_issue();
    wait_busy(n);
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== 64'h00000000_80000000) begin failures++; $display("FAIL div_overflow got=%h exp=0000000080000000", {hi, lo}); end

    drive_issue(3'd3, 32'd100, 32'd7, 1'b1);
    clock_issue();
    wait_busy(n);
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL divu_result got=%h exp=%h", {hi, lo}, e); end

    drive_issue(3'd4, 32'h11, 32'h0, 1'b1);
    clock_issue();
    e = sb_q.pop_front();
    drive_issue(3'd5, 32'h22, 32'h0, 1'b1);
    clock_issue();
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL mthi_mtlo got=%h exp=%h", {hi, lo}, e); end

    drive_issue(3'd3, 32'd7, 32'd0, 1'b1);
    clock_issue();
    wait_busy(n);
    checks++; if (n != DC) begin failures++; $display("FAIL divzero_busy_cycles got=%0d exp=%0d", n, DC); end
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== 64'h00000011_00000022) begin failures++; $display("FAIL divzero_unchanged got=%h exp=0000001100000022", {hi, lo}); end
  endtask

  task automatic test_stall();
    int n;
    logic [63:0] e;
    d_md = 1'b1;
    drive_issue(3'd0, 32'd5, 32'd6, 1'b1);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_issue got=%b exp=1", stall); end
    clock_issue();
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_busy_cycle%0d got=%b exp=1", n, stall); end
      @(posedge clk); #1;
    end
    checks++; if (n != MC) begin failures++; $display("FAIL stall_busy_cycles got=%0d exp=%0d", n, MC); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_after got=%b exp=0", stall); end
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL stall_result got=%h exp=%h", {hi, lo}, e); end

    drive_issue(3'd4, 32'h1234, 32'h0, 1'b1);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mthi_stall got=%b exp=0", stall); end
    clock_issue();
    e = sb_q.pop_front();
    checks++; if (hi !== 32'h1234) begin failures++; $display("FAIL mthi_value got=%h exp=%h", hi, 32'h1234); end
    d_md = 1'b0;
  endtask

  task automatic test_flush();
    d_md  = 1'b1;
    flush = 1'b1;
    drive_issue(3'd0, 32'd9, 32'd9, 1'b0);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall); end
    clock_issue();
    flush = 1'b0;
    d_md  = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL flush_hilo got=%h exp=%h", {hi, lo}, {m_hi, m_lo}); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [63:0] e;
    drive_issue(3'd0, 32'd7, 32'hFFFFFFFD, 1'b1);
    clock_issue();
    wait_busy(n);
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL b2b_first got=%h exp=%h", {hi, lo}, e); end
    drive_issue(3'd1, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    clock_issue();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_second_issue got=%b exp=1", busy); end
    wait_busy(n);
    checks++; if (n != MC) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=%0d", n, MC); end
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL b2b_second got=%h exp=%h", {hi, lo}, e); end
  endtask

  task automatic test_abort();
    int n;
    logic [63:0] e;
    logic [63:0] pre;
    pre = {m_hi, m_lo};
`ifdef MD_ABORT_EN
    drive_issue(3'd2, 32'd100, 32'd7, 1'b0);
`else
    drive_issue(3'd2, 32'd100, 32'd7, 1'b1);
`endif
    clock_issue();
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
`ifdef MD_ABORT_EN
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if ({hi, lo} !== pre) begin failures++; $display("FAIL abort_hilo got=%h exp=%h", {hi, lo}, pre); end
`else
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_ignored_busy got=%b exp=1", busy); end
    wait_busy(n);
    checks++; if (n != DC - 3) begin failures++; $display("FAIL abort_ignored_cycles got=%0d exp=%0d", n, DC - 3); end
    e = sb_q.pop_front();
    checks++; if ({hi, lo} !== e || {hi, lo} === pre) begin failures++; $display("FAIL abort_ignored_commit got=%h exp=%h", {hi, lo}, e); end
`endif
  endtask

  task automatic test_reset_mid();
    drive_issue(3'd0, 32'hDEADBEEF, 32'h1234567, 1'b0);
    clock_issue();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL resetmid_busy got=%b exp=0", busy); end
    repeat (MC + 1) @(posedge clk);
    #1;
    checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL resetmid_hilo got=%h exp=0", {hi, lo}); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; abort = 1'b0; d_md = 1'b0;
    op = 3'd0; a = 32'd0; b = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_flush();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
